// File: rtl/unified_memory_arbiter_pkg.sv
// rtl/unified_memory_arbiter_pkg.sv - shared types for the fetch/data memory arbiter
package unified_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arbState_t;

  typedef enum logic {
    OWNER_FETCH,
    OWNER_DATA
  } owner_t;

endpackage

// File: rtl/arbiter_watchdog.sv
// rtl/arbiter_watchdog.sv - saturating wait-cycle counter that flags a memory that never answers
module arbiter_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned COUNT_WIDTH = $clog2(LIMIT + 1);
  localparam logic [COUNT_WIDTH-1:0] LIMIT_VALUE = COUNT_WIDTH'(LIMIT);

  logic [COUNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT_VALUE)) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the LIMIT-th enabled cycle, so the owner spends at most LIMIT cycles waiting.
  assign expired = enable && (count >= (LIMIT_VALUE - 1'b1));

endmodule

// File: rtl/unified_memory_arbiter.sv
// rtl/unified_memory_arbiter.sv - shares one variable-latency memory between fetch and load/store
module unified_memory_arbiter
  import unified_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     fetchRequest,
  input  logic [ADDRESS_WIDTH-1:0] fetchAddress,
  output logic                     fetchDone,
  output logic [DATA_WIDTH-1:0]    fetchReadData,
  input  logic                     dataRequest,
  input  logic                     dataWrite,
  input  logic [ADDRESS_WIDTH-1:0] dataAddress,
  input  logic [DATA_WIDTH-1:0]    dataWriteData,
  output logic                     dataDone,
  output logic [DATA_WIDTH-1:0]    dataReadData,
  output logic                     memRequest,
  output logic                     memWrite,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0]    memWriteData,
  input  logic                     memAccept,
  input  logic                     memResponseValid,
  input  logic [DATA_WIDTH-1:0]    memReadData,
  output logic                     timeoutError
);

  arbState_t state, stateNext;
  owner_t    owner;

  logic startData, startFetch, accepted, responded, timedOut;
  logic waitActive, watchdogExpired;
  logic [DATA_WIDTH-1:0] captureData;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= ARB_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext  = state;
    startData  = 1'b0;
    startFetch = 1'b0;
    accepted   = 1'b0;
    responded  = 1'b0;
    timedOut   = 1'b0;
    fetchDone  = 1'b0;
    dataDone   = 1'b0;
    case (state)
      ARB_IDLE: begin
        // Data belongs to the older instruction, so it always wins a tie.
        if (dataRequest) begin
          startData = 1'b1;
          stateNext = ARB_ISSUE;
        end else if (fetchRequest) begin
          startFetch = 1'b1;
          stateNext  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (memAccept) begin
          accepted  = 1'b1;
          stateNext = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (memResponseValid) begin
          responded = 1'b1;
          stateNext = ARB_DONE;
        end else if (watchdogExpired) begin
          timedOut  = 1'b1;
          stateNext = ARB_DONE;
        end
      end
      ARB_DONE: begin
        fetchDone = (owner == OWNER_FETCH);
        dataDone  = (owner == OWNER_DATA);
        stateNext = ARB_IDLE;
      end
      default: stateNext = ARB_IDLE;
    endcase
  end

  assign waitActive  = (state == ARB_WAIT);
  assign captureData = responded ? memReadData : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      owner         <= OWNER_FETCH;
      memRequest    <= 1'b0;
      memWrite      <= 1'b0;
      memAddress    <= '0;
      memWriteData  <= '0;
      fetchReadData <= '0;
      dataReadData  <= '0;
      timeoutError  <= 1'b0;
    end else begin
      if (startData) begin
        owner        <= OWNER_DATA;
        memRequest   <= 1'b1;
        memWrite     <= dataWrite;
        memAddress   <= dataAddress;
        memWriteData <= dataWriteData;
      end else if (startFetch) begin
        owner        <= OWNER_FETCH;
        memRequest   <= 1'b1;
        memWrite     <= 1'b0;
        memAddress   <= fetchAddress;
        memWriteData <= '0;
      end else if (accepted) begin
        memRequest <= 1'b0;
      end
      // memWrite still holds the latched direction, so stores leave dataReadData alone.
      if (responded || timedOut) begin
        if (owner == OWNER_FETCH) begin
          fetchReadData <= captureData;
        end else if (!memWrite) begin
          dataReadData <= captureData;
        end
      end
      if (timedOut) begin
        timeoutError <= 1'b1;
      end
    end
  end

  arbiter_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) watchdog (
    .clk    (clk),
    .resetN (resetN),
    .clear  (accepted),
    .enable (waitActive),
    .expired(watchdogExpired)
  );

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// tb/tb_unified_memory_arbiter.sv - self-checking bench for unified_memory_arbiter
module tb_unified_memory_arbiter;

  localparam int TO = 4;

  logic        clk;
  logic        resetN;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchDone;
  logic [31:0] fetchReadData;
  logic        dataRequest;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataWriteData;
  logic        dataDone;
  logic [31:0] dataReadData;
  logic        memRequest;
  logic        memWrite;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memAccept;
  logic        memResponseValid;
  logic [31:0] memReadData;
  logic        timeoutError;

  unified_memory_arbiter #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .resetN          (resetN),
    .fetchRequest    (fetchRequest),
    .fetchAddress    (fetchAddress),
    .fetchDone       (fetchDone),
    .fetchReadData   (fetchReadData),
    .dataRequest     (dataRequest),
    .dataWrite       (dataWrite),
    .dataAddress     (dataAddress),
    .dataWriteData   (dataWriteData),
    .dataDone        (dataDone),
    .dataReadData    (dataReadData),
    .memRequest      (memRequest),
    .memWrite        (memWrite),
    .memAddress      (memAddress),
    .memWriteData    (memWriteData),
    .memAccept       (memAccept),
    .memResponseValid(memResponseValid),
    .memReadData     (memReadData),
    .timeoutError    (timeoutError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  int checks = 0;
  int errors = 0;

  // Behavioural memory plus the values each result register should hold.
  logic [31:0] memModel [256];
  logic [31:0] expFetchData;
  logic [31:0] expDataData;
  logic        expErr;

  typedef struct {
    bit          isData;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          acc;
    int          resp;
    int          expDone;
    logic [31:0] expRead;
    bit          expErr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  // One access: acc = cycles memAccept is withheld, resp = cycles from accept to response (0 = never).
  task automatic doAccess(input bit isData, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input int acc, input int resp, input bit holdFetch, input logic [31:0] holdAddr,
                          input bit noise, output int relDone, output int absDone);
    int cyc, reqCycles, acceptCyc, doneCyc, expDoneCyc, idx;
    bit effWr, fieldsOk, responded;
    logic [31:0] rdata;
    idx   = int'(addr[9:2]);
    effWr = isData && wr;
    if (isData) begin
      dataRequest = 1'b1; dataWrite = wr; dataAddress = addr; dataWriteData = wd;
    end else begin
      fetchRequest = 1'b1; fetchAddress = addr;
    end
    if (holdFetch) begin
      fetchRequest = 1'b1; fetchAddress = holdAddr;
    end
    responded  = (resp > 0) && (resp <= TO);
    expDoneCyc = 2 + acc + (responded ? resp : TO);
    cyc = 0; reqCycles = 0; acceptCyc = -1; doneCyc = -1; fieldsOk = 1'b1; absDone = -1;
    while (doneCyc < 0 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
      memAccept = 1'b0; memResponseValid = 1'b0; memReadData = $urandom;
      if (fetchDone || dataDone) begin
        doneCyc = cyc;
        absDone = cycleCount;
        check("doneOwner", {30'd0, fetchDone, dataDone}, isData ? 32'd1 : 32'd2);
        if (isData) dataRequest = 1'b0;
        else fetchRequest = 1'b0;
      end else if (memRequest) begin
        reqCycles++;
        if (memWrite !== effWr || memAddress !== addr || (effWr && memWriteData !== wd)) fieldsOk = 1'b0;
        if (reqCycles == acc + 1) begin
          memAccept = 1'b1; acceptCyc = cyc;
        end else if (noise) begin
          memResponseValid = 1'($urandom % 2);
        end
      end else if (acceptCyc > 0) begin
        if (resp > 0 && cyc == acceptCyc + resp) begin
          memResponseValid = 1'b1; memReadData = memModel[idx];
        end else if (noise) begin
          memAccept = 1'($urandom % 2);
        end
      end
    end
    rdata = responded ? memModel[idx] : 32'h0;
    if (effWr) memModel[idx] = wd;
    if (!responded) expErr = 1'b1;
    if (!isData) expFetchData = rdata;
    else if (!wr) expDataData = rdata;
    relDone = doneCyc;
    check("doneCycle", doneCyc, expDoneCyc);
    check("memRequestCycles", reqCycles, acc + 1);
    check("memFields", {31'd0, fieldsOk}, 32'd1);
    check("fetchReadData", fetchReadData, expFetchData);
    check("dataReadData", dataReadData, expDataData);
    check("timeoutError", {31'd0, timeoutError}, {31'd0, expErr});
    @(posedge clk); #1;
    memAccept = 1'b0; memResponseValid = 1'b0;
    check("donePulseWidth", {30'd0, fetchDone, dataDone}, 32'd0);
    check("idleMemRequest", {31'd0, memRequest}, 32'd0);
  endtask

  initial begin
    int rel, absData, absFetch;
    resetN = 1'b0;
    fetchRequest = 1'b0; fetchAddress = '0;
    dataRequest = 1'b0; dataWrite = 1'b0; dataAddress = '0; dataWriteData = '0;
    memAccept = 1'b0; memResponseValid = 1'b0; memReadData = '0;
    for (int i = 0; i < 256; i++) memModel[i] = {16'hA5A5, 16'(i)};
    memModel[16] = 32'h00500093;
    expFetchData = '0; expDataData = '0; expErr = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        0, 1, 3, 32'h00500093, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h104, 32'h0,        3, 2, 7, 32'hA5A50041, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h44,  32'h0,        1, 4, 7, 32'hA5A50011, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h108, 32'h12345678, 2, 1, 5, 32'hA5A50041, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h108, 32'h0,        0, 3, 5, 32'h12345678, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h10C, 32'h0,        0, 0, 6, 32'h00000000, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 32'h48,  32'h0,        0, 1, 3, 32'hA5A50012, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 32'h104, 32'h0,        1, 1, 4, 32'hA5A50041, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("rstMemRequest", {31'd0, memRequest}, 32'd0);
    check("rstDones", {30'd0, fetchDone, dataDone}, 32'd0);
    check("rstFetchReadData", fetchReadData, 32'd0);
    check("rstDataReadData", dataReadData, 32'd0);
    check("rstTimeoutError", {31'd0, timeoutError}, 32'd0);
    check("rstMemAddress", memAddress, 32'd0);
    resetN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      doAccess(vecs[i].isData, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].acc, vecs[i].resp,
               1'b0, 32'h0, 1'b0, rel, absData);
      check($sformatf("vec%0d_done", i), rel, vecs[i].expDone);
      check($sformatf("vec%0d_data", i), vecs[i].isData ? dataReadData : fetchReadData, vecs[i].expRead);
      check($sformatf("vec%0d_err", i), {31'd0, timeoutError}, {31'd0, vecs[i].expErr});
    end

    // Both requesters raised together: the store goes first, the fetch follows four cycles later.
    doAccess(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 0, 1, 1'b1, 32'h4C, 1'b0, rel, absData);
    doAccess(1'b0, 1'b0, 32'h4C, 32'h0, 0, 1, 1'b0, 32'h0, 1'b0, rel, absFetch);
    check("fetchAfterData", absFetch - absData, 4);
    doAccess(1'b1, 1'b0, 32'h100, 32'h0, 0, 1, 1'b0, 32'h0, 1'b0, rel, absData);
    check("loadAfterStore", dataReadData, 32'hDEADBEEF);

    // Reset while waiting on the memory, then a late response that must be ignored.
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h110;
    @(posedge clk); #1;
    check("preRstIssue", {31'd0, memRequest}, 32'd1);
    memAccept = 1'b1;
    @(posedge clk); #1;
    memAccept = 1'b0;
    #2 resetN = 1'b0;
    #1;
    check("midRstMemRequest", {31'd0, memRequest}, 32'd0);
    check("midRstDones", {30'd0, fetchDone, dataDone}, 32'd0);
    check("midRstDataReadData", dataReadData, 32'd0);
    check("midRstFetchReadData", fetchReadData, 32'd0);
    check("midRstTimeoutError", {31'd0, timeoutError}, 32'd0);
    dataRequest = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    memResponseValid = 1'b1; memReadData = 32'hBAD0BAD0;
    @(posedge clk); #1;
    memResponseValid = 1'b0;
    check("lateRespDones", {30'd0, fetchDone, dataDone}, 32'd0);
    check("lateRespData", dataReadData, 32'd0);
    expFetchData = '0; expDataData = '0; expErr = 1'b0;
    doAccess(1'b0, 1'b0, 32'h40, 32'h0, 0, 1, 1'b0, 32'h0, 1'b0, rel, absFetch);

    for (int i = 0; i < 40; i++) begin
      doAccess(1'($urandom % 2), 1'($urandom % 2), {22'd0, 8'($urandom), 2'b00}, $urandom,
               int'($urandom % 4), int'($urandom % 6), 1'b0, 32'h0, 1'b1, rel, absData);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL globalTimeout: simulation did not reach the end");
    $fatal(1);
  end

endmodule
